// File: rtl/axis_mem_cmd_engine.sv
// rtl/axis_mem_cmd_engine.sv - AXI-Stream command engine driving a single-port byte memory
module axis_mem_cmd_engine #(
  parameter int ADDR_W     = 16,
  parameter int RD_LATENCY = 1,
  parameter bit WR_ACK     = 1'b0
) (
  input  logic              core_clk,
  input  logic              rst_n,
  input  logic [31:0]       s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [31:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [7:0]        dina,
  input  logic [7:0]        douta,
  output logic [15:0]       cmd_cnt,
  output logic [7:0]        err_cnt
);

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_PING  = 8'h0F;
  localparam logic [7:0] OP_ERR   = 8'hEE;

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;

  state_t      state;
  logic [7:0]  op_q;
  logic [15:0] addr_q;
  logic [7:0]  data_q;
  logic        tlast_q;
  logic [1:0]  wait_cnt;
  logic [7:0]  in_op;

  assign in_op = s_axis_tdata[31:24];

  // Command FSM: accept, drive the memory for one cycle, wait for read data, hold the response
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      s_axis_tready <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      ena           <= 1'b0;
      wea           <= 1'b0;
      addra         <= '0;
      dina          <= '0;
      cmd_cnt       <= '0;
      err_cnt       <= '0;
      op_q          <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      tlast_q       <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      // Memory strobes are single-cycle pulses; they default low every cycle
      ena <= 1'b0;
      wea <= 1'b0;
      case (state)
        IDLE: begin
          s_axis_tready <= 1'b1;
          if (s_axis_tvalid && s_axis_tready) begin
            op_q          <= in_op;
            addr_q        <= s_axis_tdata[23:8];
            data_q        <= s_axis_tdata[7:0];
            tlast_q       <= s_axis_tlast;
            cmd_cnt       <= cmd_cnt + 16'd1;
            s_axis_tready <= 1'b0;
            // Strobes are registered here so they are visible exactly during EXEC
            addra         <= s_axis_tdata[8 +: ADDR_W];
            dina          <= s_axis_tdata[7:0];
            ena           <= (in_op == OP_WRITE) || (in_op == OP_READ);
            wea           <= (in_op == OP_WRITE);
            state         <= EXEC;
          end
        end
        EXEC: begin
          case (op_q)
            OP_WRITE: begin
              if (WR_ACK) begin
                m_axis_tdata  <= {OP_WRITE, addr_q, data_q};
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= tlast_q;
                state         <= RESP;
              end else begin
                s_axis_tready <= 1'b1;
                state         <= IDLE;
              end
            end
            OP_READ: begin
              wait_cnt <= 2'(RD_LATENCY);
              state    <= WAIT;
            end
            OP_PING: begin
              m_axis_tdata  <= {OP_PING, 16'hA55A, 8'h00};
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= tlast_q;
              state         <= RESP;
            end
            default: begin
              m_axis_tdata  <= {OP_ERR, addr_q, op_q};
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= tlast_q;
              if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
              end
              state <= RESP;
            end
          endcase
        end
        WAIT: begin
          // douta is valid in the cycle the counter sits at 1
          if (wait_cnt == 2'd1) begin
            m_axis_tdata  <= {OP_READ, addr_q, douta};
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= tlast_q;
            state         <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        RESP: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            s_axis_tready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_mem_cmd_engine.sv
// tb/tb_axis_mem_cmd_engine.sv - randomized self-checking bench for axis_mem_cmd_engine
module tb_axis_mem_cmd_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_tdata [2];
  logic        s_tvalid [2];
  logic        s_tready [2];
  logic        s_tlast [2];
  logic [31:0] m_tdata [2];
  logic        m_tvalid [2];
  logic        m_tready [2];
  logic        m_tlast [2];
  logic        ena [2];
  logic        wea [2];
  logic [15:0] addra [2];
  logic [7:0]  dina [2];
  logic [7:0]  douta [2];
  logic [15:0] cmd_cnt [2];
  logic [7:0]  err_cnt [2];

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0]  ref_mem [int];
  logic [15:0] wq0 [$];
  logic [15:0] wq1 [$];
  int          exp_cmd [2];
  int          exp_err [2];

  always #5 clk = ~clk;

  // Instance 0: RD_LATENCY=1, no write ack. Instance 1: RD_LATENCY=2, write ack.
  for (genvar g = 0; g < 2; g++) begin : g_env
    logic [7:0] mem [0:65535];
    logic [7:0] rd1, rd2;

    axis_mem_cmd_engine #(.ADDR_W(16), .RD_LATENCY(g + 1), .WR_ACK(g == 1)) u_dut (
      .core_clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_tdata[g]), .s_axis_tvalid(s_tvalid[g]),
      .s_axis_tready(s_tready[g]), .s_axis_tlast(s_tlast[g]),
      .m_axis_tdata(m_tdata[g]), .m_axis_tvalid(m_tvalid[g]),
      .m_axis_tready(m_tready[g]), .m_axis_tlast(m_tlast[g]),
      .ena(ena[g]), .wea(wea[g]), .addra(addra[g]), .dina(dina[g]), .douta(douta[g]),
      .cmd_cnt(cmd_cnt[g]), .err_cnt(err_cnt[g])
    );

    always @(posedge clk) begin
      if (ena[g] && wea[g]) mem[addra[g]] <= dina[g];
      if (ena[g] && !wea[g]) rd1 <= mem[addra[g]];
      rd2 <= rd1;
    end
    assign douta[g] = (g == 0) ? rd1 : rd2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_resp(input int sel, input logic [31:0] cmd);
    logic [7:0] op;
    op = cmd[31:24];
    case (op)
      8'h01:   return {8'h01, cmd[23:8], cmd[7:0]};
      8'h02:   return {8'h02, cmd[23:8], ref_mem[sel * 65536 + int'(cmd[23:8])]};
      8'h0F:   return 32'h0FA55A00;
      default: return {8'hEE, cmd[23:8], op};
    endcase
  endfunction

  task automatic model_accept(input int sel, input logic [31:0] cmd);
    exp_cmd[sel] = (exp_cmd[sel] + 1) % 65536;
    case (cmd[31:24])
      8'h01: begin
        ref_mem[sel * 65536 + int'(cmd[23:8])] = cmd[7:0];
        if (sel == 0) wq0.push_back(cmd[23:8]);
        else wq1.push_back(cmd[23:8]);
      end
      8'h02, 8'h0F: ;
      default: if (exp_err[sel] < 255) exp_err[sel]++;
    endcase
  endtask

  task automatic check_strobes(input int sel, input logic [31:0] cmd);
    logic [7:0] op;
    op = cmd[31:24];
    check("ena_pulse", ena[sel], (op == 8'h01) || (op == 8'h02));
    check("wea_pulse", wea[sel], op == 8'h01);
    if (op == 8'h01 || op == 8'h02) check("addra", addra[sel], cmd[23:8]);
    if (op == 8'h01) check("dina", dina[sel], cmd[7:0]);
  endtask

  task automatic wait_ready(input int sel);
    int wait_n;
    wait_n = 0;
    while (!s_tready[sel] && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check("accept_timeout", wait_n < 20, 1);
  endtask

  // One complete command: accept, strobe check, response latency/backpressure/data, counters
  task automatic do_cmd(input int sel, input logic [31:0] cmd, input logic last, input int bp);
    logic [7:0]  op;
    logic [31:0] want, hold;
    int          lat, exp_lat;
    bit          resp;
    op = cmd[31:24];
    want = exp_resp(sel, cmd);
    resp = (op != 8'h01) || (sel == 1);
    exp_lat = (op == 8'h02) ? 2 + sel : 1;
    s_tdata[sel] = cmd;
    s_tvalid[sel] = 1'b1;
    s_tlast[sel] = last;
    wait_ready(sel);
    @(posedge clk);
    @(negedge clk);
    s_tvalid[sel] = 1'b0;
    model_accept(sel, cmd);
    check_strobes(sel, cmd);
    if (!resp) begin
      @(negedge clk);
      check("wr_ready_back", s_tready[sel], 1);
      check("wr_no_resp", m_tvalid[sel], 0);
      check("ena_one_cycle", ena[sel], 0);
    end else begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
        if (lat == 1) check("ena_one_cycle", ena[sel], 0);
      end while (!m_tvalid[sel] && lat < 20);
      check("resp_latency", lat, exp_lat);
      hold = m_tdata[sel];
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        check("bp_valid", m_tvalid[sel], 1);
        check("bp_data", m_tdata[sel], hold);
        check("bp_busy", s_tready[sel], 0);
      end
      check("resp_data", m_tdata[sel], want);
      check("resp_last", m_tlast[sel], last);
      m_tready[sel] = 1'b1;
      @(negedge clk);
      m_tready[sel] = 1'b0;
      check("resp_drop", m_tvalid[sel], 0);
      check("ready_back", s_tready[sel], 1);
    end
    check("cmd_cnt", cmd_cnt[sel], exp_cmd[sel]);
    check("err_cnt", err_cnt[sel], exp_err[sel]);
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      check("rst_tready", s_tready[s], 0);
      check("rst_tvalid", m_tvalid[s], 0);
      check("rst_ena", ena[s], 0);
      check("rst_wea", wea[s], 0);
      check("rst_cmd_cnt", cmd_cnt[s], 0);
      check("rst_err_cnt", err_cnt[s], 0);
      exp_cmd[s] = 0;
      exp_err[s] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("tready_before_edge", s_tready[0], 0);
    @(negedge clk);
    check("tready_after_edge", s_tready[0], 1);
    check("tready_after_edge1", s_tready[1], 1);
  endtask

  initial begin
    logic [31:0] b2b [4];
    for (int s = 0; s < 2; s++) begin
      s_tdata[s] = '0;
      s_tvalid[s] = 1'b0;
      s_tlast[s] = 1'b0;
      m_tready[s] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_tdata", m_tdata[s], 0);
      check("rst_tlast", m_tlast[s], 0);
      check("rst_addra", addra[s], 0);
      check("rst_dina", dina[s], 0);
    end
    apply_reset();

    // Write then read back on both latency configurations
    do_cmd(0, 32'h0112345A, 1'b0, 0);
    do_cmd(0, 32'h02123400, 1'b1, 0);
    check("readback_lit", exp_resp(0, 32'h02123400), 32'h0212345A);
    do_cmd(1, 32'h01123477, 1'b1, 0);
    do_cmd(1, 32'h02123400, 1'b0, 1);

    // Ping under long backpressure
    do_cmd(0, 32'h0F000000, 1'b1, 10);

    // Illegal opcodes and error counter saturation
    apply_reset();
    do_cmd(0, 32'h7E00FF33, 1'b0, 0);
    check("err_one", err_cnt[0], 8'h01);
    for (int i = 0; i < 300; i++) do_cmd(0, 32'hC0000000 | (i & 32'hFFFF), i[0], 0);
    check("err_sat", err_cnt[0], 8'hFF);
    check("cmd_301", cmd_cnt[0], 16'd301);

    // Back-to-back writes with tvalid held high
    b2b[0] = 32'h011010A1; b2b[1] = 32'h011011B2; b2b[2] = 32'h011012C3; b2b[3] = 32'h011013D4;
    begin
      int acc_cyc [4];
      int cyc;
      cyc = 0;
      s_tvalid[0] = 1'b1;
      for (int k = 0; k < 4; k++) begin
        s_tdata[0] = b2b[k];
        s_tlast[0] = (k == 3);
        while (!s_tready[0] && cyc < 200) begin
          @(negedge clk);
          cyc++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        acc_cyc[k] = cyc;
        model_accept(0, b2b[k]);
        check_strobes(0, b2b[k]);
        if (k > 0) check("b2b_spacing", acc_cyc[k] - acc_cyc[k-1], 2);
      end
      s_tvalid[0] = 1'b0;
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) do_cmd(0, {8'h02, b2b[k][23:8], 8'h00}, k[0], 0);

    // Write acks in order
    for (int k = 0; k < 4; k++) do_cmd(1, {8'h01, b2b[k][23:8], b2b[k][7:0] ^ 8'hFF}, k[0], k);

    // Reset during the WAIT state of a read
    s_tdata[1] = 32'h02123400;
    s_tvalid[1] = 1'b1;
    s_tlast[1] = 1'b0;
    wait_ready(1);
    @(posedge clk);
    @(negedge clk);
    s_tvalid[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", m_tvalid[1], 0);
    check("midrst_ena", ena[1], 0);
    check("midrst_cmd_cnt", cmd_cnt[1], 0);
    check("midrst_err_cnt", err_cnt[0], 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      exp_cmd[s] = 0;
      exp_err[s] = 0;
    end
    m_tready[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale_resp", m_tvalid[1], 0);
    end
    m_tready[1] = 1'b0;
    do_cmd(1, 32'h02123400, 1'b1, 2);

    // Randomized command mix on both configurations
    for (int sel = 0; sel < 2; sel++) begin
      for (int n = 0; n < 40; n++) begin
        int         kind;
        logic [7:0] op;
        logic [15:0] a;
        logic [7:0] d;
        kind = $urandom_range(0, 9);
        a = 16'($urandom);
        d = 8'($urandom);
        if (kind <= 3) op = 8'h01;
        else if (kind <= 6) begin
          op = 8'h02;
          if (sel == 0) a = wq0[$urandom_range(0, wq0.size() - 1)];
          else a = wq1[$urandom_range(0, wq1.size() - 1)];
        end else if (kind == 7) op = 8'h0F;
        else begin
          op = 8'($urandom);
          while (op == 8'h01 || op == 8'h02 || op == 8'h0F) op = 8'($urandom);
        end
        do_cmd(sel, {op, a, d}, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
